// File: rtl/mips_pipeline_cpu.sv
// Five-stage pipelined MIPS-subset core (IF, ID, EX, MEM, WB) with private
// instruction memory, byte-addressed big-endian data memory and a 32x32
// register file. There is no hazard detection and no forwarding. Software
// must place NOPs between dependent instructions. A taken beq resolves in
// MEM, so the three instructions already fetched behind it still execute.
// Pipeline register suffixes: _p1 = IF/ID, _p2 = ID/EX, _p3 = EX/MEM,
// _p4 = MEM/WB.
module mips_pipeline_cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 1024
) (
  input logic clk,
  input logic reset
);
  localparam int DATA_W = 32;
  localparam int IAW    = $clog2(IMEM_WORDS);
  localparam int DAW    = $clog2(DMEM_BYTES);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;

  logic [DATA_W-1:0] imem [IMEM_WORDS];
  logic [7:0]        dmem [DMEM_BYTES];
  logic [DATA_W-1:0] regs [32];

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Big-endian load formatting: 00 word, 01 signed half, 10 signed byte.
  function automatic logic [DATA_W-1:0] load_fmt(input logic [1:0] mode,
                                                 input logic [7:0] b0, input logic [7:0] b1,
                                                 input logic [7:0] b2, input logic [7:0] b3);
    case (mode)
      2'b01:   return {{16{b0[7]}}, b0, b1};
      2'b10:   return {{24{b0[7]}}, b0};
      default: return {b0, b1, b2, b3};
    endcase
  endfunction

  // ---------------- IF ----------------
  logic [DATA_W-1:0] pc, pc4, pc_next, instr;
  logic [IAW-1:0]    iidx;

  // ---------------- IF/ID ----------------
  logic [DATA_W-1:0] pc4_p1, instr_p1;

  // ---------------- ID ----------------
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] rd1, rd2, imm_ext;
  logic              regdst, regwrite, alusrc, memwrite, memread, memtoreg, branch;
  logic [1:0]        loadmode;
  alu_op_e           aluop;

  // ---------------- ID/EX ----------------
  logic [4:0]        rt_p2, rd_p2;
  logic [DATA_W-1:0] imm_p2, rd1_p2, rd2_p2, pc4_p2;
  logic              regdst_p2, regwrite_p2, alusrc_p2, memwrite_p2, memread_p2;
  logic              memtoreg_p2, branch_p2;
  logic [1:0]        loadmode_p2;
  alu_op_e           aluop_p2;

  // ---------------- EX ----------------
  logic [DATA_W-1:0]        opb, alu_y, target;
  logic signed [DATA_W-1:0] sa, sb;
  logic [4:0]               shamt, dst;

  // ---------------- EX/MEM ----------------
  logic              regwrite_p3, memwrite_p3, memread_p3, memtoreg_p3, branch_p3, zero_p3;
  logic [1:0]        loadmode_p3;
  logic [DATA_W-1:0] target_p3, alu_p3, wd_p3;
  logic [4:0]        dst_p3;

  // ---------------- MEM ----------------
  logic [DAW-1:0]    a0, a1, a2, a3;
  logic [DATA_W-1:0] mem_rdata;

  // ---------------- MEM/WB ----------------
  logic [4:0]        dst_p4;
  logic              regwrite_p4, memtoreg_p4;
  logic [DATA_W-1:0] rdata_p4, alu_p4;

  // ---------------- WB ----------------
  logic              wb_we;
  logic [DATA_W-1:0] wb_data;

  assign iidx    = IAW'((pc >> 2) % IMEM_WORDS);
  assign instr   = imem[iidx];
  assign pc4     = pc + 32'd4;
  assign pc_next = (branch_p3 && zero_p3) ? target_p3 : pc4;

  // Program counter; a taken branch in MEM redirects the fetch.
  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  // IF/ID stage boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc4_p1   <= '0;
      instr_p1 <= '0;
    end else begin
      pc4_p1   <= pc4;
      instr_p1 <= instr;
    end
  end

  assign opcode  = instr_p1[31:26];
  assign rs      = instr_p1[25:21];
  assign rt      = instr_p1[20:16];
  assign rd      = instr_p1[15:11];
  assign funct   = instr_p1[5:0];
  assign imm_ext = sext16(instr_p1[15:0]);

  // Main decoder; unrecognised encodings leave every control bit clear.
  always_comb begin
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrc   = 1'b0;
    memwrite = 1'b0;
    memread  = 1'b0;
    memtoreg = 1'b0;
    branch   = 1'b0;
    loadmode = 2'b00;
    aluop    = ALU_ADD;
    case (opcode)
      6'h00: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        case (funct)
          6'h20:   aluop = ALU_ADD;
          6'h22:   aluop = ALU_SUB;
          6'h24:   aluop = ALU_AND;
          6'h25:   aluop = ALU_OR;
          6'h2A:   aluop = ALU_SLT;
          6'h00:   aluop = ALU_SLL;
          6'h02:   aluop = ALU_SRL;
          default: begin
            regdst   = 1'b0;
            regwrite = 1'b0;
          end
        endcase
      end
      6'h08: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
      6'h23, 6'h21, 6'h20: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        memread  = 1'b1;
        memtoreg = 1'b1;
        loadmode = (opcode == 6'h21) ? 2'b01 : (opcode == 6'h20) ? 2'b10 : 2'b00;
      end
      6'h2B: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      6'h04: begin
        branch = 1'b1;
        aluop  = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign wb_we   = regwrite_p4 && (dst_p4 != 5'd0);
  assign wb_data = memtoreg_p4 ? rdata_p4 : alu_p4;

  // Register reads; $0 is hard zero and a same-cycle write is passed through.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != 5'd0) rd1 = (wb_we && dst_p4 == rs) ? wb_data : regs[rs];
    if (rt != 5'd0) rd2 = (wb_we && dst_p4 == rt) ? wb_data : regs[rt];
  end

  // ID/EX stage boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      rt_p2 <= '0; rd_p2 <= '0; imm_p2 <= '0; rd1_p2 <= '0; rd2_p2 <= '0; pc4_p2 <= '0;
      regdst_p2 <= 1'b0; regwrite_p2 <= 1'b0; alusrc_p2 <= 1'b0; memwrite_p2 <= 1'b0;
      memread_p2 <= 1'b0; memtoreg_p2 <= 1'b0; branch_p2 <= 1'b0;
      loadmode_p2 <= 2'b00; aluop_p2 <= ALU_ADD;
    end else begin
      rt_p2 <= rt; rd_p2 <= rd; imm_p2 <= imm_ext; rd1_p2 <= rd1; rd2_p2 <= rd2; pc4_p2 <= pc4_p1;
      regdst_p2 <= regdst; regwrite_p2 <= regwrite; alusrc_p2 <= alusrc; memwrite_p2 <= memwrite;
      memread_p2 <= memread; memtoreg_p2 <= memtoreg; branch_p2 <= branch;
      loadmode_p2 <= loadmode; aluop_p2 <= aluop;
    end
  end

  assign opb    = alusrc_p2 ? imm_p2 : rd2_p2;
  assign sa     = rd1_p2;
  assign sb     = opb;
  assign shamt  = imm_p2[10:6];
  assign target = pc4_p2 + (imm_p2 << 2);
  assign dst    = regdst_p2 ? rd_p2 : rt_p2;

  // ALU: 32-bit wrap-around arithmetic, signed set-less-than, logical shifts.
  always_comb begin
    alu_y = '0;
    case (aluop_p2)
      ALU_ADD: alu_y = rd1_p2 + opb;
      ALU_SUB: alu_y = rd1_p2 - opb;
      ALU_AND: alu_y = rd1_p2 & opb;
      ALU_OR:  alu_y = rd1_p2 | opb;
      ALU_SLT: alu_y = {31'd0, (sa < sb)};
      ALU_SLL: alu_y = opb << shamt;
      ALU_SRL: alu_y = opb >> shamt;
      default: alu_y = '0;
    endcase
  end

  // EX/MEM stage boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_p3 <= 1'b0; memwrite_p3 <= 1'b0; memread_p3 <= 1'b0; memtoreg_p3 <= 1'b0;
      branch_p3 <= 1'b0; zero_p3 <= 1'b0; loadmode_p3 <= 2'b00;
      target_p3 <= '0; alu_p3 <= '0; wd_p3 <= '0; dst_p3 <= '0;
    end else begin
      regwrite_p3 <= regwrite_p2; memwrite_p3 <= memwrite_p2; memread_p3 <= memread_p2;
      memtoreg_p3 <= memtoreg_p2; branch_p3 <= branch_p2; zero_p3 <= (alu_y == '0);
      loadmode_p3 <= loadmode_p2;
      target_p3 <= target; alu_p3 <= alu_y; wd_p3 <= rd2_p2; dst_p3 <= dst;
    end
  end

  assign a0 = DAW'(alu_p3 % DMEM_BYTES);
  assign a1 = DAW'((alu_p3 + 32'd1) % DMEM_BYTES);
  assign a2 = DAW'((alu_p3 + 32'd2) % DMEM_BYTES);
  assign a3 = DAW'((alu_p3 + 32'd3) % DMEM_BYTES);
  assign mem_rdata = memread_p3 ? load_fmt(loadmode_p3, dmem[a0], dmem[a1], dmem[a2], dmem[a3]) : '0;

  // Data memory store port, big-endian, suppressed while reset discards the pipe.
  always_ff @(posedge clk) begin
    if (!reset && memwrite_p3) begin
      dmem[a0] <= wd_p3[31:24];
      dmem[a1] <= wd_p3[23:16];
      dmem[a2] <= wd_p3[15:8];
      dmem[a3] <= wd_p3[7:0];
    end
  end

  // MEM/WB stage boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_p4 <= '0; regwrite_p4 <= 1'b0; memtoreg_p4 <= 1'b0; rdata_p4 <= '0; alu_p4 <= '0;
    end else begin
      dst_p4 <= dst_p3; regwrite_p4 <= regwrite_p3; memtoreg_p4 <= memtoreg_p3;
      rdata_p4 <= mem_rdata; alu_p4 <= alu_p3;
    end
  end

  // Register file write-back; reset clears every register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[dst_p4] <= wb_data;
    end
  end
endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// Bench for mips_pipeline_cpu: table of R-type vectors, hand-written
// multi-cycle sequences, and random hazard-free programs checked
// against an instruction-level reference model.
module tb_mips_pipeline_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_pipeline_cpu #(.IMEM_WORDS(256), .DMEM_BYTES(1024)) dut (.clk(clk), .reset(reset));

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[11];

  logic [31:0] mr [32];
  logic [7:0]  mm [1024];
  logic [31:0] prog [96];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_regs_zero(input string nm, input int skip);
    for (int i = 0; i < 32; i++)
      if (i != skip) chk($sformatf("%s_r%0d", nm, i), dut.regs[i], 32'h0);
  endtask

  // Instruction-level reference: one architectural instruction at a time.
  task automatic iss_exec(input logic [31:0] ins);
    logic [31:0] a, b, sx, v;
    logic [4:0]  dst;
    int unsigned ad;
    bit wr;
    a = mr[ins[25:21]];
    b = mr[ins[20:16]];
    sx = {{16{ins[15]}}, ins[15:0]};
    ad = (a + sx) % 1024;
    dst = ins[20:16];
    wr = 0;
    v = 0;
    case (ins[31:26])
      6'h00: begin
        dst = ins[15:11];
        wr = 1;
        case (ins[5:0])
          6'h20: v = a + b;
          6'h22: v = a - b;
          6'h24: v = a & b;
          6'h25: v = a | b;
          6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: v = b << ins[10:6];
          6'h02: v = b >> ins[10:6];
          default: wr = 0;
        endcase
      end
      6'h08: begin wr = 1; v = a + sx; end
      6'h23: begin wr = 1; v = {mm[ad], mm[ad+1], mm[ad+2], mm[ad+3]}; end
      6'h21: begin wr = 1; v = {{16{mm[ad][7]}}, mm[ad], mm[ad+1]}; end
      6'h20: begin wr = 1; v = {{24{mm[ad][7]}}, mm[ad]}; end
      6'h2B: begin
        mm[ad] = b[31:24]; mm[ad+1] = b[23:16]; mm[ad+2] = b[15:8]; mm[ad+3] = b[7:0];
      end
      default: ;
    endcase
    if (wr && dst != 5'd0) mr[dst] = v;
  endtask

  initial begin
    vt[0]  = '{a:32'd5,          b:32'd7,          fn:6'h20, sh:5'd0,  exp:32'h0000000C};
    vt[1]  = '{a:32'hFFFFFFFF,   b:32'd1,          fn:6'h20, sh:5'd0,  exp:32'h00000000};
    vt[2]  = '{a:32'd3,          b:32'd5,          fn:6'h22, sh:5'd0,  exp:32'hFFFFFFFE};
    vt[3]  = '{a:32'hF0F0F0F0,   b:32'hFF00FF00,   fn:6'h24, sh:5'd0,  exp:32'hF000F000};
    vt[4]  = '{a:32'h0F0F0000,   b:32'h000000F0,   fn:6'h25, sh:5'd0,  exp:32'h0F0F00F0};
    vt[5]  = '{a:32'hFFFFFFFF,   b:32'd1,          fn:6'h2A, sh:5'd0,  exp:32'h00000001};
    vt[6]  = '{a:32'd1,          b:32'hFFFFFFFF,   fn:6'h2A, sh:5'd0,  exp:32'h00000000};
    vt[7]  = '{a:32'h80000000,   b:32'h7FFFFFFF,   fn:6'h2A, sh:5'd0,  exp:32'h00000001};
    vt[8]  = '{a:32'h12345678,   b:32'd1,          fn:6'h00, sh:5'd31, exp:32'h80000000};
    vt[9]  = '{a:32'h12345678,   b:32'h80000000,   fn:6'h02, sh:5'd4,  exp:32'h08000000};
    vt[10] = '{a:32'h80000000,   b:32'd1,          fn:6'h22, sh:5'd0,  exp:32'h7FFFFFFF};

    // Single addi: latency and PC progression.
    clear_imem();
    dut.imem[0] = 32'h20090002;
    do_reset();
    chk("rst_pc", dut.pc, 32'h0);
    step(4);
    chk("lat_pc4", dut.pc, 32'd16);
    chk("lat_r9_early", dut.regs[9], 32'h0);
    step(1);
    chk("lat_r9", dut.regs[9], 32'd2);
    chk("lat_pc5", dut.pc, 32'd20);
    chk_regs_zero("lat", 9);

    // R-type vector table: operands loaded from data memory.
    for (int k = 0; k < 11; k++) begin
      clear_imem();
      dut.imem[0] = enc_i(6'h23, 0, 8, 0);
      dut.imem[1] = enc_i(6'h23, 0, 9, 4);
      dut.imem[4] = enc_r(8, 9, 10, vt[k].sh, vt[k].fn);
      for (int j = 0; j < 4; j++) begin
        dut.dmem[j]   = vt[k].a[31-8*j -: 8];
        dut.dmem[4+j] = vt[k].b[31-8*j -: 8];
      end
      do_reset();
      step(12);
      chk($sformatf("vec%0d", k), dut.regs[10], vt[k].exp);
    end

    // add/sub/slt with NOP padding.
    clear_imem();
    dut.imem[0] = 32'h20080004;
    dut.imem[3] = enc_r(8, 8, 10, 0, 6'h20);
    dut.imem[4] = enc_r(0, 8, 11, 0, 6'h22);
    dut.imem[7] = enc_r(11, 8, 12, 0, 6'h2A);
    do_reset();
    step(15);
    chk("add_r10", dut.regs[10], 32'd8);
    chk("sub_r11", dut.regs[11], 32'hFFFFFFFC);
    chk("slt_r12", dut.regs[12], 32'd1);

    // sw then lw, big-endian layout.
    clear_imem();
    for (int j = 8; j < 12; j++) dut.dmem[j] = 8'hAA;
    dut.imem[0] = enc_i(6'h08, 0, 1, 16'h1234);
    dut.imem[3] = enc_i(6'h2B, 0, 1, 8);
    dut.imem[4] = enc_i(6'h23, 0, 2, 8);
    do_reset();
    step(12);
    chk("sw_b8",  {24'd0, dut.dmem[8]},  32'h00);
    chk("sw_b9",  {24'd0, dut.dmem[9]},  32'h00);
    chk("sw_b10", {24'd0, dut.dmem[10]}, 32'h12);
    chk("sw_b11", {24'd0, dut.dmem[11]}, 32'h34);
    chk("lw_r2", dut.regs[2], 32'h1234);

    // Sub-word signed loads of 0x000080FF.
    clear_imem();
    for (int j = 0; j < 4; j++) dut.dmem[j] = 8'h55;
    dut.imem[0] = enc_i(6'h08, 0, 5, 16'h7FFF);
    dut.imem[3] = enc_i(6'h08, 5, 5, 16'h0100);
    dut.imem[6] = enc_i(6'h2B, 0, 5, 0);
    dut.imem[7] = enc_i(6'h21, 0, 3, 2);
    dut.imem[8] = enc_i(6'h20, 0, 4, 3);
    dut.imem[9] = enc_i(6'h23, 0, 13, 0);
    dut.imem[10] = enc_i(6'h20, 0, 6, 2);
    dut.imem[11] = enc_i(6'h21, 0, 7, 0);
    do_reset();
    step(20);
    chk("sub_r5", dut.regs[5], 32'h000080FF);
    chk("lh_r3", dut.regs[3], 32'hFFFF80FF);
    chk("lb_r4", dut.regs[4], 32'hFFFFFFFF);
    chk("lw_r13", dut.regs[13], 32'h000080FF);
    chk("lb_r6", dut.regs[6], 32'hFFFFFF80);
    chk("lh_r7", dut.regs[7], 32'h00000000);

    // Taken branch with three executed shadow instructions.
    clear_imem();
    dut.imem[0] = 32'h10000004;
    for (int j = 1; j <= 5; j++) dut.imem[j] = enc_i(6'h08, 0, j, j);
    do_reset();
    step(3);
    chk("beq_pc3", dut.pc, 32'd12);
    step(1);
    chk("beq_pc4", dut.pc, 32'd20);
    step(10);
    chk("beq_r1", dut.regs[1], 32'd1);
    chk("beq_r2", dut.regs[2], 32'd2);
    chk("beq_r3", dut.regs[3], 32'd3);
    chk("beq_r4_skipped", dut.regs[4], 32'd0);
    chk("beq_r5", dut.regs[5], 32'd5);

    // Not-taken branch.
    clear_imem();
    dut.imem[0] = 32'h20080004;
    dut.imem[3] = 32'h11000004;
    for (int j = 1; j <= 5; j++) dut.imem[3+j] = enc_i(6'h08, 0, j, j);
    do_reset();
    step(7);
    chk("bne_pc7", dut.pc, 32'd28);
    step(10);
    chk("bne_r4", dut.regs[4], 32'd4);
    chk("bne_r5", dut.regs[5], 32'd5);

    // $0 is immutable; unknown opcode is a NOP.
    clear_imem();
    dut.imem[0] = 32'h20000005;
    dut.imem[3] = enc_i(6'h08, 0, 1, 7);
    dut.imem[4] = enc_i(6'h0D, 0, 10, 16'h55);
    do_reset();
    step(12);
    chk("r0_zero", dut.regs[0], 32'h0);
    chk("r0_read", dut.regs[1], 32'd7);
    chk("unk_op", dut.regs[10], 32'h0);

    // Reset mid-run discards in-flight work.
    clear_imem();
    for (int j = 1; j <= 8; j++) dut.imem[j-1] = enc_i(6'h08, 0, j, 16'h11 * j);
    do_reset();
    step(6);
    chk("mid_r2_pre", dut.regs[2], 32'h22);
    do_reset();
    clear_imem();
    chk("mid_pc", dut.pc, 32'h0);
    chk_regs_zero("mid_rst", -1);
    step(10);
    chk("mid_pc10", dut.pc, 32'd40);
    chk_regs_zero("mid_stale", -1);

    // Random hazard-free programs against the reference model.
    for (int p = 0; p < 10; p++) begin
      int mis;
      for (int j = 0; j < 1024; j++) begin
        mm[j] = 8'($urandom);
        dut.dmem[j] = mm[j];
      end
      for (int j = 0; j < 32; j++) mr[j] = 32'h0;
      for (int j = 0; j < 96; j++) prog[j] = 32'h0;
      for (int k = 0; k < 24; k++) begin
        int kind;
        int fsel;
        logic [5:0] fns [7];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        kind = $urandom_range(0, 5);
        fsel = $urandom_range(0, 6);
        case (kind)
          0: prog[3*k] = enc_i(6'h08, $urandom_range(0, 15), $urandom_range(1, 15), $urandom);
          1: prog[3*k] = enc_r($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                               $urandom_range(0, 31), fns[fsel]);
          2: prog[3*k] = enc_i(6'h23, 0, $urandom_range(0, 15), $urandom_range(0, 1020));
          3: prog[3*k] = enc_i(6'h21, 0, $urandom_range(0, 15), $urandom_range(0, 1020));
          4: prog[3*k] = enc_i(6'h20, 0, $urandom_range(0, 15), $urandom_range(0, 1020));
          default: prog[3*k] = enc_i(6'h2B, 0, $urandom_range(0, 15), $urandom_range(0, 1020));
        endcase
      end
      clear_imem();
      for (int j = 0; j < 96; j++) dut.imem[j] = prog[j];
      for (int j = 0; j < 72; j++) iss_exec(prog[j]);
      do_reset();
      step(80);
      for (int r = 0; r < 32; r++) chk($sformatf("rnd%0d_r%0d", p, r), dut.regs[r], mr[r]);
      mis = 0;
      for (int j = 0; j < 1024; j++) if (dut.dmem[j] !== mm[j]) mis++;
      chk($sformatf("rnd%0d_dmem_diffs", p), mis, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
